// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
//   - size encodings (funct3 style) for load/store requests
//   - FSM state encoding for the controller sequencer
//   - default memory size in bytes
//   - helpers for request legality and load-result extension
package dmem_pkg;

    localparam int MEM_BYTES_DEFAULT = 16384;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    // Stores only accept signed-style sizes; loads also accept the unsigned forms.
    function automatic logic size_ok(input logic write, input logic [2:0] size);
        logic ok;
        case (size)
            SZ_B, SZ_H, SZ_W: ok = 1'b1;
            SZ_BU, SZ_HU:     ok = !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size);
        logic [31:0] res;
        case (size)
            SZ_B:    res = {{24{word[7]}}, word[7:0]};
            SZ_H:    res = {{16{word[15]}}, word[15:0]};
            SZ_BU:   res = {24'd0, word[7:0]};
            SZ_HU:   res = {16'd0, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ctrl_arbiter.sv
// Two-requester arbiter for the data memory controller (module dmem_rr_arbiter).
// Ports:
//   clk, rst_n, accept  - only present with DMEM_CTRL_RR_EN (pointer update)
//   req[1:0]            - request lines, bit n = port n
//   grant[1:0]          - one-hot grant (zero when nothing requested)
// Configuration macro DMEM_CTRL_RR_EN:
//   defined   - round-robin; pointer holds last granted port, reset to port 1
//   undefined - fixed priority, port 0 always wins, no state
module dmem_rr_arbiter (
`ifdef DMEM_CTRL_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef DMEM_CTRL_RR_EN
    logic last_port;

    // Pointer resets to port 1 so that port 0 wins the very first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (accept) begin
            last_port <= grant[1];
        end
    end

    // On a tie the port that was not granted last time wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_port ? 2'b01 : 2'b10;
        end
    end
`else
    assign grant = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory sequencing controller and two-port arbiter.
// Accepts load/store requests from port 0 (core LSU) and port 1 (debug/DMA),
// issues word-wide memory accesses, turns sub-word stores into
// read-modify-write, size-extends load data, and flags illegal requests.
// Ports:
//   clk, rst_n                        - clock, async active-low reset
//   pN_valid/ready/addr/wdata/write/size - request handshake and fields
//   pN_rvalid                         - one-cycle completion pulse per port
//   rdata, rerr                       - shared completion data / error flag
//   mem_addr, mem_wdata, mem_write    - memory command (decoded from state)
//   mem_rdata                         - registered memory read data
// Configuration macro DMEM_CTRL_RR_EN selects round-robin arbitration
// (default build: fixed priority to port 0).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_write,
    input  logic [2:0]  p0_size,
    output logic        p0_rvalid,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_write,
    input  logic [2:0]  p1_size,
    output logic        p1_rvalid,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [1:0]  grant;
    logic        take;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_write;
    logic [2:0]  sel_size;
    logic        sel_err;
    logic [31:0] addr_q, wdata_q;
    logic        write_q, err_q, port_q;
    logic [2:0]  size_q;

    dmem_rr_arbiter u_arb (
`ifdef DMEM_CTRL_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (take),
`endif
        .req    ({p1_valid, p0_valid}),
        .grant  (grant)
    );

    assign take      = (state_q == IDLE) && (grant != 2'b00);
    assign sel_addr  = grant[1] ? p1_addr  : p0_addr;
    assign sel_wdata = grant[1] ? p1_wdata : p0_wdata;
    assign sel_write = grant[1] ? p1_write : p0_write;
    assign sel_size  = grant[1] ? p1_size  : p0_size;

    // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
    assign sel_err = !size_ok(sel_write, sel_size) ||
                     (({1'b0, sel_addr} + 33'd4) > ADDR_LIMIT);

    // State register plus the request fields captured on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            err_q   <= 1'b0;
            port_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                write_q <= sel_write;
                size_q  <= sel_size;
                err_q   <= sel_err;
                port_q  <= grant[1];
            end
        end
    end

    // All outputs are decoded from state so reset clears them at once.
    // Sub-word stores read in RD; mem_rdata then holds the old word during WR.
    always_comb begin
        state_d   = state_q;
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        rdata     = '0;
        rerr      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                p0_ready = grant[0];
                p1_ready = grant[1];
                if (take) begin
                    if (sel_err) begin
                        state_d = RESP;
                    end else if (sel_write && (sel_size == SZ_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_addr = addr_q;
                state_d  = write_q ? WR : RESP;
            end
            WR: begin
                mem_addr  = addr_q;
                mem_write = 1'b1;
                case (size_q)
                    SZ_B:    mem_wdata = {mem_rdata[31:8], wdata_q[7:0]};
                    SZ_H:    mem_wdata = {mem_rdata[31:16], wdata_q[15:0]};
                    default: mem_wdata = wdata_q;
                endcase
                state_d = RESP;
            end
            RESP: begin
                p0_rvalid = !port_q;
                p1_rvalid = port_q;
                rerr      = err_q;
                if (!write_q && !err_q) begin
                    rdata = load_extend(mem_rdata, size_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller and two-port arbiter in front of the byte-addressable data memory. It accepts load/store requests from the core load/store unit (port 0) and a secondary master such as debug or DMA (port 1), and issues word-wide reads and writes to the memory. Sub-word stores become read-modify-write sequences, and load results are size-extended. Out-of-range or illegal-size accesses complete with an error and never touch memory.

## Interface
- MEM_BYTES, 16384: memory size in bytes; an access is legal when addr + 4 <= MEM_BYTES.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_valid / p1_valid  in  1  request valid.
- p0_ready / p1_ready  out  1  request accepted this cycle.
- p0_addr / p1_addr  in  32  byte address.
- p0_wdata / p1_wdata  in  32  store data, right-aligned.
- p0_write / p1_write  in  1  1 = store, 0 = load.
- p0_size / p1_size  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- p0_rvalid / p1_rvalid  out  1  one-cycle completion pulse for that port.
- rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rerr  out  1  error flag, qualified by either rvalid.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_write  out  1  memory write strobe; writes bytes addr..addr+3.
- mem_rdata  in  32  memory read data, registered; valid the cycle after mem_addr is presented.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - Arbiter picks a port with valid high and drives that port's ready for one cycle.
  - Request fields are latched on that edge.
  - The other port's ready stays 0.
- Next state after accept:
  - Error: RESP with rerr = 1.
  - Load: RD.
  - Word store: WR.
  - Byte or half store: RD.
- RD: mem_addr = latched addr, mem_write = 0. Next state is RESP for a load, WR for a sub-word store.
- WR: mem_addr = addr, mem_write = 1, mem_wdata as follows.
  - Word store: wdata.
  - Byte or half store: mem_rdata with the low byte or halfword replaced by wdata.
  - Next state RESP.
- RESP:
  - rvalid pulses on the granted port.
  - Load: rdata = mem_rdata extended per size. 000/001 sign-extend bit 7/15; 100/101 zero-extend; 010 passes through.
  - Next state IDLE.
- Error conditions:
  - addr + 4 > MEM_BYTES, computed in 33 bits so no wrap-around.
  - Load size 011, 110 or 111.
  - Store size other than 000, 001 or 010.
- Unaligned addresses are legal; no alignment check.
- One request outstanding; ready is never high outside IDLE.

## Timing
- Latency from accept edge to rvalid cycle:
  - Error: 1.
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- Store data is in memory by the edge ending WR. A load accepted afterwards returns the new value.
- Reset values:
  - State IDLE.
  - All ready, rvalid and rerr 0.
  - rdata, mem_addr and mem_wdata 0.
  - mem_write 0.
  - Arbiter pointer = port 1, so port 0 wins the first tie.
- Reset asserted mid-sequence:
  - mem_write drops immediately (decoded from state).
  - No rvalid is produced.
  - The aborted request is lost; the requester must reissue.
- Requests may change or drop while not accepted; nothing is latched without ready.
- Both valid in the same IDLE cycle: arbitration rule below. The loser keeps valid high and is served next.

## Configuration
- DMEM_CTRL_RR_EN defined: round-robin. The pointer records the last granted port; on a tie the other port wins; the pointer updates on accept.
- DMEM_CTRL_RR_EN undefined: fixed priority, port 0 always wins. The pointer register is absent.

## Structure
- Package dmem_pkg holds:
  - Size encodings: SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
  - FSM state encoding.
  - Default MEM_BYTES.
- Sub-module dmem_rr_arbiter: two request inputs, one-hot grant, pointer register under DMEM_CTRL_RR_EN.

## Test plan
- Port 0 SW 0xDEADBEEF @ 0x100, then LW @ 0x100: p0_rvalid 2 cycles after each accept; rdata = 0xDEADBEEF, rerr = 0.
- After the above, SB 0x7F @ 0x100, then LB and LBU @ 0x100:
  - SB completes in 3 cycles, mem_write high for exactly 1 cycle.
  - Word becomes 0xDEADBE7F.
  - LB returns 0x0000007F; LBU returns 0x0000007F.
- SH 0x8001 @ 0x200, then LH and LHU @ 0x200: LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW @ MEM_BYTES-3 and SW with size 100:
  - rvalid 1 cycle after accept, rerr = 1, rdata = 0.
  - mem_write never asserted.
  - Memory unchanged.
- Both ports hold valid continuously:
  - With DMEM_CTRL_RR_EN, grants alternate 0,1,0,1.
  - Without it, port 0 is granted every time and port 1 starves.
- rst_n pulsed low during the WR cycle of an SB:
  - mem_write falls immediately and all outputs take reset values.
  - No rvalid.
  - The next request is accepted normally after release.
